// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers: payload
// field layout, occupancy/state encoding and the NOP bubble payload.
package pipe_pkg;

    // Payload layout: five 32-bit data words, then writereg and alu_low.
    localparam int PIPE_PAYLOAD_W = 167;

    localparam int INSTR_OFF    = 0;
    localparam int PC_OFF       = 32;
    // pcchu travels in the pc slot; both are never live in the same stage.
    localparam int PCCHU_OFF    = PC_OFF;
    localparam int DM_OFF       = 64;
    localparam int ALU_OFF      = 96;
    localparam int HILO_OFF     = 128;
    localparam int WORD_W       = 32;
    localparam int WRITEREG_OFF = 160;
    localparam int WRITEREG_W   = 5;
    localparam int ALU_LOW_OFF  = 165;
    localparam int ALU_LOW_W    = 2;

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // An all-zero payload is a NOP bubble.
    localparam logic [PIPE_PAYLOAD_W-1:0] NOP_PAYLOAD = '0;

    // Assemble a payload from its fields.
    function automatic logic [PIPE_PAYLOAD_W-1:0] pack_payload(
        input logic [WORD_W-1:0]     instr,
        input logic [WORD_W-1:0]     pc,
        input logic [WORD_W-1:0]     dm,
        input logic [WORD_W-1:0]     alu,
        input logic [WORD_W-1:0]     hilo,
        input logic [WRITEREG_W-1:0] writereg,
        input logic [ALU_LOW_W-1:0]  alu_low
    );
        logic [PIPE_PAYLOAD_W-1:0] p;
        p = NOP_PAYLOAD;
        p[INSTR_OFF    +: WORD_W]     = instr;
        p[PC_OFF       +: WORD_W]     = pc;
        p[DM_OFF       +: WORD_W]     = dm;
        p[ALU_OFF      +: WORD_W]     = alu;
        p[HILO_OFF     +: WORD_W]     = hilo;
        p[WRITEREG_OFF +: WRITEREG_W] = writereg;
        p[ALU_LOW_OFF  +: ALU_LOW_W]  = alu_low;
        return p;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One payload register with synchronous reset, synchronous clear and load enable.
module pipe_stage_reg #(
    parameter int W = 167
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    // Reset and clear both zero the entry (NOP bubble); otherwise load on enable.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and payload stable until accepted; the
// consumer may change ready freely. With SKID=1 in_ready depends only on
// state registers; with SKID=0 it also follows out_ready combinationally.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic [1:0]           state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 main_en, skid_en;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                 in_xfer, out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? (state_q != ST_FULL) : (~out_valid | out_ready);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Next state and payload moves; a cleared entry reloads with zeros.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = '0;
        skid_en = 1'b0;
        skid_d  = '0;
        if (SKID == 0) begin
            if (in_xfer) begin
                state_d = ST_ONE;
                main_en = 1'b1;
                main_d  = in_payload;
            end else if (out_xfer) begin
                state_d = ST_EMPTY;
                main_en = 1'b1;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        main_en = 1'b1;
                        main_d  = in_payload;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d = ST_FULL;
                        skid_en = 1'b1;
                        skid_d  = in_payload;
                    end else if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                        main_d  = in_payload;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                        main_en = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        main_en = 1'b1;
                        main_d  = skid_q;
                        skid_en = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Occupancy state; flush empties the stage and drops any incoming transfer.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_stage_reg #(.W(PAYLOAD_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_stage_reg #(.W(PAYLOAD_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (skid_en),
        .d     (skid_d),
        .q     (skid_q)
    );

    // Stall counter saturates at all-ones; flush leaves it untouched.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_payload = out_valid ? main_q : '0;
    assign occupancy   = state_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three instances (SKID=1, SKID=0, SKID=1 with
// a 3-bit stall counter) share one stimulus stream and are checked against a
// queue model of each stage.
module tb_pipe_stage_elastic;

    localparam int W = 167;
    localparam int N = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_payload;
    logic         flush;
    logic         out_ready;

    logic         rdy [N];
    logic         vld [N];
    logic [W-1:0] pl  [N];
    logic [1:0]   occ [N];
    logic [15:0]  stall0, stall1;
    logic [2:0]   stall2;

    pipe_stage_elastic #(.PAYLOAD_W(W), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_payload(in_payload), .flush(flush), .out_valid(vld[0]),
        .out_ready(out_ready), .out_payload(pl[0]), .occupancy(occ[0]),
        .stall_cnt(stall0)
    );

    pipe_stage_elastic #(.PAYLOAD_W(W), .SKID(0), .CNT_W(16)) u_single (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_payload(in_payload), .flush(flush), .out_valid(vld[1]),
        .out_ready(out_ready), .out_payload(pl[1]), .occupancy(occ[1]),
        .stall_cnt(stall1)
    );

    pipe_stage_elastic #(.PAYLOAD_W(W), .SKID(1), .CNT_W(3)) u_cnt3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_payload(in_payload), .flush(flush), .out_valid(vld[2]),
        .out_ready(out_ready), .out_payload(pl[2]), .occupancy(occ[2]),
        .stall_cnt(stall2)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q [N][$];
    int           cap      [N] = '{2, 1, 2};
    longint       sat      [N] = '{65535, 65535, 7};
    longint       exp_stall[N];

    int compared   = 0;
    int mismatched = 0;

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input int idx, input logic [W-1:0] obs,
                       input logic [W-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s[%0d] t=%0t: got %0h expected %0h", tag, idx, $time, obs, expv);
        end
    endtask

    function automatic logic [15:0] stall_of(input int idx);
        case (idx)
            0:       return stall0;
            1:       return stall1;
            default: return {13'd0, stall2};
        endcase
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle: apply inputs, check outputs before the edge, then
    // advance the model across the edge.
    task automatic step(input logic rst, input logic iv, input logic [W-1:0] p,
                        input logic fl, input logic ordy);
        logic m_rdy [N];
        logic m_vld [N];
        reset = rst; in_valid = iv; in_payload = p; flush = fl; out_ready = ordy;
        #1;
        for (int i = 0; i < N; i++) begin
            m_vld[i] = (exp_q[i].size() > 0);
            if (cap[i] == 2) m_rdy[i] = (exp_q[i].size() < 2);
            else             m_rdy[i] = (exp_q[i].size() == 0) || ordy;
            chk("in_ready",    i, W'(rdy[i]), W'(m_rdy[i]));
            chk("out_valid",   i, W'(vld[i]), W'(m_vld[i]));
            chk("out_payload", i, pl[i], m_vld[i] ? exp_q[i][0] : '0);
            chk("occupancy",   i, W'(occ[i]), W'(exp_q[i].size()));
            chk("stall_cnt",   i, W'(stall_of(i)), W'(exp_stall[i]));
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                exp_q[i].delete();
                exp_stall[i] = 0;
            end else begin
                if (m_vld[i] && !ordy && exp_stall[i] < sat[i]) exp_stall[i]++;
                if (fl) begin
                    exp_q[i].delete();
                end else begin
                    if (m_vld[i] && ordy) void'(exp_q[i].pop_front());
                    if (iv && m_rdy[i]) exp_q[i].push_back(p);
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_pl();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        t[0] = 1'b1;
        return t[W-1:0];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] a, b, c;
        reset = 1'b1; in_valid = 1'b0; in_payload = '0; flush = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) exp_stall[i] = 0;
        @(negedge clk);

        // Reset, then idle.
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 0);

        // Stream 1..8 at full throughput, then drain.
        for (int k = 1; k <= 8; k++) step(0, 1, W'(k), 0, 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);

        // Back-pressure: A and B in, hold out_ready low, then drain.
        a = rand_pl();
        b = rand_pl();
        step(0, 1, a, 0, 0);
        step(0, 1, b, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, rand_pl(), 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, '0, 0, 1);

        // Flush while full with C offered: C must never appear.
        step(0, 1, rand_pl(), 0, 0);
        step(0, 1, rand_pl(), 0, 0);
        c = rand_pl();
        step(0, 1, c, 1, 0);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);

        // Stall saturation from a fresh reset.
        step(1, 0, '0, 0, 0);
        step(0, 1, rand_pl(), 0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);

        // out_ready toggling with continuous input.
        for (int k = 0; k < 8; k++) step(0, 1, rand_pl(), 0, (k % 2) == 0);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rand_pl(),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
